serial_rx_fifo: RTL
===================

SERIAL_RX_FIFO -- requirements
Module: serial_rx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clk cycles per serial bit (100 MHz / 115200); legal range 8..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, receive buffer entries; power of two, 2..256.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port uart_rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 SHALL have port rd_en  input  1  pop request for the head byte.
REQ-007 SHALL have port err_clr  input  1  clears sticky error flags.
REQ-008 SHALL have port rd_data  output  8  head byte, first-word-fall-through.
REQ-009 SHALL have port rd_valid  output  1  FIFO non-empty.
REQ-010 SHALL have port count  output  $clog2(FIFO_DEPTH)+1  bytes held.
REQ-011 SHALL have port frame_err  output  1  sticky; stop bit sampled low.
REQ-012 SHALL have port overflow  output  1  sticky; byte dropped because FIFO full.

Function
REQ-013 SHALL pass uart_rx through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-014 SHALL implement states IDLE, START, DATA, STOP; with SERIAL_RX_PARITY_EN also PARITY, between DATA and STOP.
REQ-015 IDLE: a synchronized high-to-low transition SHALL enter START and load the bit counter with CLKS_PER_BIT/2-1.
REQ-016 START: at counter expiry, line low -> DATA; line high -> IDLE (glitch rejected, nothing written, no error).
REQ-017 DATA: SHALL sample every CLKS_PER_BIT cycles, 8 samples, shifting LSB first, then advance.
REQ-018 STOP: one CLKS_PER_BIT later; line high -> push byte; line low -> discard byte, set frame_err, wait for line high before IDLE.
REQ-019 A pushed byte SHALL appear on rd_data with rd_valid high on the cycle after the stop-bit sample.
REQ-020 rd_en with rd_valid high SHALL pop the head on that edge; rd_en with FIFO empty SHALL be ignored.
REQ-021 Push while full with no pop SHALL drop the byte and set overflow; FIFO contents unchanged.
REQ-022 Simultaneous push and pop while full SHALL accept both; count unchanged.
REQ-023 Simultaneous push and pop while empty SHALL write the byte and leave count 1 (pop ignored).
REQ-024 Read/write pointers SHALL wrap modulo FIFO_DEPTH; count SHALL range 0..FIFO_DEPTH.
REQ-025 err_clr SHALL clear frame_err and overflow; a same-cycle set event SHALL win over err_clr.
REQ-026 The receiver SHALL resynchronize on the next falling edge after any completed or aborted frame; back-to-back frames with one stop bit SHALL be received without loss.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, counters 0, pointers 0, count 0, rd_valid 0, rd_data 8'h00, frame_err 0, overflow 0, synchronizer flops 1.
REQ-028 Reset mid-frame SHALL discard the partial byte; after release, reception SHALL start only on a fresh falling edge.

Configuration
REQ-029 Macro SERIAL_RX_PARITY_EN defined: frame is 8E1; PARITY state samples a bit, even-parity mismatch discards the byte and sets frame_err.
REQ-030 Macro SERIAL_RX_PARITY_EN undefined: frame is 8N1, no PARITY state, no parity logic present.

Verification
REQ-031 Bench SHALL cover: CLKS_PER_BIT=8, send 8'hA5 8N1 -> rd_valid rises the cycle after stop sample, rd_data=8'hA5, count=1; rd_en one cycle -> count=0, rd_valid=0.
REQ-032 Bench SHALL cover: uart_rx low for 2 cycles then high -> state returns IDLE, count stays 0, frame_err stays 0.
REQ-033 Bench SHALL cover: 17 back-to-back bytes 0x00..0x10, FIFO_DEPTH=16, no reads -> count=16, overflow=1, reads return 0x00..0x0F in order; err_clr -> overflow=0.
REQ-034 Bench SHALL cover: 8'h3C with stop bit driven low -> frame_err=1, count=0; next valid byte 8'h55 is received correctly.
REQ-035 Bench SHALL cover: rst_n asserted during bit 4 of a frame -> all outputs at reset values; subsequent 8'h81 is received correctly.
REQ-036 Bench SHALL cover: with SERIAL_RX_PARITY_EN, 8'h07 with parity bit 0 -> frame_err=1, byte dropped; parity bit 1 -> rd_data=8'h07.

Source files
------------

// File: rtl/serial_rx_fifo.sv
// UART receiver (8N1) feeding a first-word-fall-through byte FIFO with sticky error flags.
// Define SERIAL_RX_PARITY_EN to receive 8E1 frames with an even-parity check.
module serial_rx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        uart_rx,
    input  logic                        rd_en,
    input  logic                        err_clr,
    output logic [7:0]                  rd_data,
    output logic                        rd_valid,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        frame_err,
    output logic                        overflow
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TMR_W = 16;
    localparam logic [TMR_W-1:0] BIT_RELOAD  = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [TMR_W-1:0] HALF_RELOAD = TMR_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
`ifdef SERIAL_RX_PARITY_EN
        , S_PARITY
`endif
    } state_t;

    state_t           state;
    logic [TMR_W-1:0] tmr;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             err_wait;
    logic             rx_meta;
    logic             rx_sync;
    logic             rx_prev;
`ifdef SERIAL_RX_PARITY_EN
    logic             par_ok;
`endif

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic             stop_sample_c;
    logic             frame_ok_c;
    logic             push_c;
    logic             pop_c;
    logic             full_c;
    logic             wr_c;
    logic             ovf_set_c;
    logic             fe_set_c;
    logic [PTR_W-1:0] rd_ptr_nxt_c;
    logic [CNT_W-1:0] count_nxt_c;

    // Two-flop synchronizer plus one history flop for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Receive FSM: samples mid-bit, timer counts down to each sample point.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            tmr      <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            err_wait <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            par_ok   <= 1'b1;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        state <= S_START;
                        tmr   <= HALF_RELOAD;
                    end
                end
                S_START: begin
                    if (tmr == '0) begin
                        if (!rx_sync) begin
                            state   <= S_DATA;
                            tmr     <= BIT_RELOAD;
                            bit_idx <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end
                S_DATA: begin
                    if (tmr == '0) begin
                        shift   <= {rx_sync, shift[7:1]};
                        tmr     <= BIT_RELOAD;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef SERIAL_RX_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end
`ifdef SERIAL_RX_PARITY_EN
                S_PARITY: begin
                    if (tmr == '0) begin
                        par_ok <= (rx_sync == ^shift);
                        tmr    <= BIT_RELOAD;
                        state  <= S_STOP;
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end
`endif
                S_STOP: begin
                    // After a low stop bit, hold here until the line idles high again.
                    if (err_wait) begin
                        if (rx_sync) begin
                            err_wait <= 1'b0;
                            state    <= S_IDLE;
                        end
                    end else if (tmr == '0) begin
                        if (rx_sync) begin
                            state <= S_IDLE;
                        end else begin
                            err_wait <= 1'b1;
                        end
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        stop_sample_c = (state == S_STOP) && !err_wait && (tmr == '0);
`ifdef SERIAL_RX_PARITY_EN
        frame_ok_c    = rx_sync && par_ok;
`else
        frame_ok_c    = rx_sync;
`endif
        push_c        = stop_sample_c && frame_ok_c;
        fe_set_c      = stop_sample_c && !frame_ok_c;
        pop_c         = rd_en && (count != '0);
        full_c        = (count == CNT_W'(FIFO_DEPTH));
        wr_c          = push_c && (!full_c || pop_c);
        ovf_set_c     = push_c && full_c && !pop_c;
        rd_ptr_nxt_c  = pop_c ? rd_ptr + PTR_W'(1) : rd_ptr;
        count_nxt_c   = count;
        if (wr_c && !pop_c) begin
            count_nxt_c = count + CNT_W'(1);
        end else if (!wr_c && pop_c) begin
            count_nxt_c = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_c) begin
            mem[wr_ptr] <= shift;
        end
    end

    // FIFO bookkeeping; rd_data is pre-fetched so the head is always registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rd_valid  <= 1'b0;
            rd_data   <= 8'h00;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (wr_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr   <= rd_ptr_nxt_c;
            count    <= count_nxt_c;
            rd_valid <= (count_nxt_c != '0);
            if (wr_c && (count == CNT_W'(pop_c))) begin
                rd_data <= shift;
            end else begin
                rd_data <= mem[rd_ptr_nxt_c];
            end
            if (fe_set_c) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end
            if (ovf_set_c) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule
